// File: rtl/rfft_host_ctrl.sv
// Host loader/unloader for the rfft core: serial stream -> 4-lane RAM writes, run, 4-lane reads -> serial stream.
// Latency: lane-3 beat accepted at t -> fft_write at t+1; first output beat RD_LAT+1 cycles after UNLOAD entry.
// Backpressure: s_ready low outside LOAD; m_valid/m_data hold until m_ready; reads throttled by a 2-entry word buffer.
//
// Ports:
//   Clk, Reset               single clock, synchronous active-high reset
//   s_data/s_valid/s_ready   input sample stream (lane-interleaved, addr-major)
//   m_data/m_valid/m_ready   output sample stream, m_last on the final beat of a frame
//   fft_din0..3, fft_addr,
//   fft_input, fft_write     rfft RAM port driven by the host
//   fft_done, fft_dout0..3   rfft completion flag and RAM read data
//   busy                     high while the core runs or the frame is being unloaded
//   run_cycles               RUN-phase cycle count, present only with RFFT_HOST_CYCCNT_EN defined
//
// Optional feature macro: RFFT_HOST_CYCCNT_EN
module rfft_host_ctrl #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 64,
   parameter int RD_LAT = 1
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [WIDTH-1:0]         s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [WIDTH-1:0]         m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic [WIDTH-1:0]         fft_din0,
   output logic [WIDTH-1:0]         fft_din1,
   output logic [WIDTH-1:0]         fft_din2,
   output logic [WIDTH-1:0]         fft_din3,
   output logic [$clog2(DEPTH)-1:0] fft_addr,
   output logic                     fft_input,
   output logic                     fft_write,
   input  logic                     fft_done,
   input  logic [WIDTH-1:0]         fft_dout0,
   input  logic [WIDTH-1:0]         fft_dout1,
   input  logic [WIDTH-1:0]         fft_dout2,
   input  logic [WIDTH-1:0]         fft_dout3,
   output logic                     busy
`ifdef RFFT_HOST_CYCCNT_EN
   ,
   output logic [15:0]              run_cycles
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = AW + 2;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_UNLOAD = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   // Shared beat counter: input beats in LOAD, output beats in UNLOAD.
   logic [BW-1:0]     r_beat;
   logic [WIDTH-1:0]  r_lane [0:3];
   logic              r_wr_pend;
   logic [AW-1:0]     r_wr_addr;
   logic              r_load_done;
   logic              r_run_first;

   logic [AW-1:0]     r_rd_addr;
   logic              r_rd_all;
   logic [RD_LAT-1:0] r_rd_vld;
   logic [WIDTH-1:0]  r_buf [0:1][0:3];
   logic              r_wp;
   logic              r_rp;
   logic [1:0]        r_cnt;

   logic              w_s_fire;
   logic              w_m_fire;
   logic              w_pop;
   logic              w_push;
   logic              w_issue;
   logic              w_beat_max;
   logic [7:0]        w_inflight;
   logic [7:0]        w_used;

   assign w_beat_max = (r_beat == {BW{1'b1}});
   assign w_s_fire   = s_valid & s_ready;
   assign w_m_fire   = m_valid & m_ready;
   // A buffer entry is released when its lane-3 beat is accepted.
   assign w_pop      = w_m_fire & (r_beat[1:0] == 2'd3);
   assign w_push     = r_rd_vld[RD_LAT-1];

   // Reads in flight reserve a buffer entry, so the buffer can never overflow.
   always_comb begin
      w_inflight = 8'd0;
      for (int i = 0; i < RD_LAT; i++) begin
         w_inflight = w_inflight + {7'd0, r_rd_vld[i]};
      end
      w_used  = {6'd0, r_cnt} + w_inflight;
      w_issue = (r_state == ST_UNLOAD) && !r_rd_all &&
                ((w_used - {7'd0, w_pop}) < 8'd2);
   end

   // Outputs
   assign s_ready   = (r_state == ST_LOAD) && !r_load_done;
   assign m_valid   = (r_state == ST_UNLOAD) && (r_cnt != 2'd0);
   assign m_data    = r_buf[r_rp][r_beat[1:0]];
   assign m_last    = m_valid && w_beat_max;
   assign fft_input = (r_state != ST_RUN);
   assign fft_write = r_wr_pend;
   assign fft_addr  = (r_state == ST_UNLOAD) ? r_rd_addr : r_wr_addr;
   assign fft_din0  = r_lane[0];
   assign fft_din1  = r_lane[1];
   assign fft_din2  = r_lane[2];
   assign fft_din3  = r_lane[3];
   assign busy      = (r_state != ST_LOAD);

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         // r_load_done is set the cycle the final write is presented, so the
         // core only sees Input drop after that write has landed.
         ST_LOAD:   if (r_load_done) w_state_nxt = ST_RUN;
         // The core's done flag is stale in the first RUN cycle.
         ST_RUN:    if (!r_run_first && fft_done) w_state_nxt = ST_UNLOAD;
         ST_UNLOAD: if (w_m_fire && w_beat_max) w_state_nxt = ST_LOAD;
         default:   w_state_nxt = ST_LOAD;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= ST_LOAD;
         r_beat      <= '0;
         r_wr_pend   <= 1'b0;
         r_wr_addr   <= '0;
         r_load_done <= 1'b0;
         r_run_first <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_all    <= 1'b0;
         r_rd_vld    <= '0;
         r_wp        <= 1'b0;
         r_rp        <= 1'b0;
         r_cnt       <= 2'd0;
         for (int l = 0; l < 4; l++) begin
            r_lane[l]   <= '0;
            r_buf[0][l] <= '0;
            r_buf[1][l] <= '0;
         end
      end else begin
         r_state     <= w_state_nxt;
         r_wr_pend   <= 1'b0;
         r_rd_vld[0] <= w_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            r_rd_vld[i] <= r_rd_vld[i-1];
         end

         case (r_state)
            ST_LOAD: begin
               if (w_s_fire) begin
                  r_lane[r_beat[1:0]] <= s_data;
                  if (r_beat[1:0] == 2'd3) begin
                     r_wr_pend <= 1'b1;
                     r_wr_addr <= r_beat[BW-1:2];
                  end
                  // Hold at the last beat; the counter restarts on the state change.
                  if (w_beat_max) begin
                     r_load_done <= 1'b1;
                  end else begin
                     r_beat <= r_beat + BW'(1);
                  end
               end
               if (r_load_done) begin
                  r_load_done <= 1'b0;
                  r_beat      <= '0;
                  r_run_first <= 1'b1;
               end
            end

            ST_RUN: begin
               r_run_first <= 1'b0;
               if (w_state_nxt == ST_UNLOAD) begin
                  r_beat    <= '0;
                  r_rd_addr <= '0;
                  r_rd_all  <= 1'b0;
                  r_wp      <= 1'b0;
                  r_rp      <= 1'b0;
                  r_cnt     <= 2'd0;
               end
            end

            ST_UNLOAD: begin
               if (w_issue) begin
                  if (r_rd_addr == AW'(DEPTH - 1)) begin
                     r_rd_all <= 1'b1;
                  end else begin
                     r_rd_addr <= r_rd_addr + AW'(1);
                  end
               end
               if (w_push) begin
                  r_buf[r_wp][0] <= fft_dout0;
                  r_buf[r_wp][1] <= fft_dout1;
                  r_buf[r_wp][2] <= fft_dout2;
                  r_buf[r_wp][3] <= fft_dout3;
                  r_wp           <= ~r_wp;
               end
               if (w_pop) begin
                  r_rp <= ~r_rp;
               end
               case ({w_push, w_pop})
                  2'b10:   r_cnt <= r_cnt + 2'd1;
                  2'b01:   r_cnt <= r_cnt - 2'd1;
                  default: r_cnt <= r_cnt;
               endcase
               if (w_m_fire) begin
                  r_beat <= r_beat + BW'(1);
               end
               if (w_state_nxt == ST_LOAD) begin
                  r_beat    <= '0;
                  r_rd_addr <= '0;
                  r_rd_all  <= 1'b0;
                  r_wp      <= 1'b0;
                  r_rp      <= 1'b0;
               end
            end

            default: begin
               r_beat <= '0;
            end
         endcase
      end
   end

`ifdef RFFT_HOST_CYCCNT_EN
   logic [15:0] r_run_cycles;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_run_cycles <= 16'd0;
      end else if ((r_state == ST_LOAD) && (w_state_nxt == ST_RUN)) begin
         r_run_cycles <= 16'd0;
      end else if ((r_state == ST_RUN) && (r_run_cycles != 16'hFFFF)) begin
         r_run_cycles <= r_run_cycles + 16'd1;
      end
   end

   assign run_cycles = r_run_cycles;
`endif

endmodule

// File: tb/tb_rfft_host_ctrl.sv
module tb_rfft_host_ctrl;

   localparam int WIDTH = 32;
   localparam int DEPTH = 64;
   localparam int DONE_AFTER = 400;

   logic             Clk = 1'b0;
   logic             Reset;
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic [WIDTH-1:0] fft_din0, fft_din1, fft_din2, fft_din3;
   logic [5:0]       fft_addr;
   logic             fft_input;
   logic             fft_write;
   logic             fft_done;
   logic [WIDTH-1:0] fft_dout0, fft_dout1, fft_dout2, fft_dout3;
   logic             busy;
`ifdef RFFT_HOST_CYCCNT_EN
   logic [15:0]      run_cycles;
`endif

   always #5 Clk = ~Clk;

   rfft_host_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(1)) dut (
      .Clk(Clk), .Reset(Reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .fft_din0(fft_din0), .fft_din1(fft_din1), .fft_din2(fft_din2), .fft_din3(fft_din3),
      .fft_addr(fft_addr), .fft_input(fft_input), .fft_write(fft_write),
      .fft_done(fft_done),
      .fft_dout0(fft_dout0), .fft_dout1(fft_dout1), .fft_dout2(fft_dout2), .fft_dout3(fft_dout3),
      .busy(busy)
`ifdef RFFT_HOST_CYCCNT_EN
      , .run_cycles(run_cycles)
`endif
   );

   // Core model: 4 lane RAMs, transform = +1000 applied when done rises,
   // done raised in the DONE_AFTER-th cycle with Input low, 1-cycle read.
   logic [WIDTH-1:0] ram [0:3][0:DEPTH-1];
   int               run_cnt = 0;

   assign fft_done = !fft_input && (run_cnt >= DONE_AFTER - 1);

   always @(posedge Clk) begin
      if (fft_input && fft_write) begin
         ram[0][fft_addr] <= fft_din0;
         ram[1][fft_addr] <= fft_din1;
         ram[2][fft_addr] <= fft_din2;
         ram[3][fft_addr] <= fft_din3;
      end
      if (fft_input) run_cnt <= 0;
      else           run_cnt <= run_cnt + 1;
      if (!fft_input && run_cnt == DONE_AFTER - 1) begin
         for (int l = 0; l < 4; l++)
            for (int a = 0; a < DEPTH; a++)
               ram[l][a] <= ram[l][a] + 1000;
      end
      fft_dout0 <= ram[0][fft_addr];
      fft_dout1 <= ram[1][fft_addr];
      fft_dout2 <= ram[2][fft_addr];
      fft_dout3 <= ram[3][fft_addr];
   end

   // Scoreboards
   typedef struct packed {
      logic [5:0]            addr;
      logic [3:0][WIDTH-1:0] din;
   } wr_t;
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } out_t;

   wr_t  exp_wr[$];
   out_t exp_out[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_writes = 0;
   int n_out = 0;
   int cyc = 0;
   int first_cyc = -1;
   int last_cyc = -1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge Clk) cyc++;

   // Write monitor
   always @(negedge Clk) begin
      wr_t e;
      if (!Reset && fft_write) begin
         n_writes++;
         if (exp_wr.size() == 0) begin
            check("wr_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_wr.pop_front();
            check("wr_addr",  fft_addr,  e.addr);
            check("wr_din0",  fft_din0,  e.din[0]);
            check("wr_din1",  fft_din1,  e.din[1]);
            check("wr_din2",  fft_din2,  e.din[2]);
            check("wr_din3",  fft_din3,  e.din[3]);
            check("wr_input", fft_input, 1'b1);
         end
      end
   end

   // Output monitor with hold-stability check
   logic             prev_stall = 1'b0;
   logic             prev_rst = 1'b1;
   logic [WIDTH-1:0] prev_data = '0;

   always @(negedge Clk) begin
      out_t o;
      if (!Reset && !prev_rst && prev_stall) begin
         check("hold_valid", m_valid, 1'b1);
         check("hold_data",  m_data,  prev_data);
      end
      if (!Reset && m_valid && m_ready) begin
         if (exp_out.size() == 0) begin
            check("out_unexpected", 64'd1, 64'd0);
         end else begin
            o = exp_out.pop_front();
            check("out_data", m_data, o.data);
            check("out_last", m_last, o.last);
         end
         n_out++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
      prev_stall = !Reset && m_valid && !m_ready;
      prev_data  = m_data;
      prev_rst   = Reset;
   end

   // Entered at posedge+1; returns at posedge+1 of the cycle after beat 255 is accepted.
   task automatic send_frame(input int base);
      wr_t  w;
      out_t o;
      int   guard;
      for (int n = 0; n < 256; n++) begin
         s_valid = 1'b1;
         s_data  = WIDTH'(base + n);
         o.data  = WIDTH'(base + n + 1000);
         o.last  = (n == 255);
         exp_out.push_back(o);
         if ((n % 4) == 3) begin
            w.addr = 6'(n / 4);
            for (int l = 0; l < 4; l++) w.din[l] = WIDTH'(base + n - 3 + l);
            exp_wr.push_back(w);
         end
         guard = 0;
         @(negedge Clk);
         while (!s_ready && guard < 50) begin
            @(negedge Clk);
            guard++;
         end
         if (!s_ready) check("s_ready_timeout", 64'd0, 64'd1);
         @(posedge Clk); #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic load_tail_checks();
      check("tail_s_ready", s_ready,   1'b0);
      check("tail_input1",  fft_input, 1'b1);
      check("tail_write",   fft_write, 1'b1);
      @(posedge Clk); #1;
      check("run_input0",   fft_input, 1'b0);
      check("run_busy",     busy,      1'b1);
      check("run_s_ready",  s_ready,   1'b0);
      check("wr_count",     n_writes,  64);
      check("wr_drained",   exp_wr.size(), 0);
   endtask

   task automatic unload(input bit rnd, input int rst_at);
      int guard;
      bit did_rst;
      guard = 0;
      did_rst = 1'b0;
      n_out = 0;
      first_cyc = -1;
      last_cyc = -1;
      while (exp_out.size() > 0 && guard < 4000 && !did_rst) begin
         if (rst_at >= 0 && n_out == rst_at) begin
            m_ready = 1'b0;
            Reset = 1'b1;
            @(posedge Clk); #1;
            check("rst_m_valid",   m_valid,   1'b0);
            check("rst_fft_input", fft_input, 1'b1);
            check("rst_s_ready",   s_ready,   1'b1);
            check("rst_busy",      busy,      1'b0);
            check("rst_fft_write", fft_write, 1'b0);
`ifdef RFFT_HOST_CYCCNT_EN
            check("rst_run_cycles", run_cycles, 16'd0);
`endif
            Reset = 1'b0;
            exp_out.delete();
            exp_wr.delete();
            did_rst = 1'b1;
         end else begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge Clk); #1;
            guard++;
         end
      end
      if (!did_rst) begin
         check("unload_drained", exp_out.size(), 0);
         check("unload_count",   n_out, 256);
         if (!rnd) check("b2b_span", last_cyc - first_cyc, 255);
         check("end_s_ready",   s_ready,   1'b1);
         check("end_busy",      busy,      1'b0);
         check("end_input",     fft_input, 1'b1);
         check("end_m_valid",   m_valid,   1'b0);
`ifdef RFFT_HOST_CYCCNT_EN
         check("run_cycles", run_cycles, 16'(DONE_AFTER));
`endif
      end
      m_ready = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      // Reset state
      @(posedge Clk); @(posedge Clk); #1;
      check("rst_s_ready",   s_ready,   1'b1);
      check("rst_m_valid",   m_valid,   1'b0);
      check("rst_m_last",    m_last,    1'b0);
      check("rst_fft_input", fft_input, 1'b1);
      check("rst_fft_write", fft_write, 1'b0);
      check("rst_fft_addr",  fft_addr,  6'd0);
      check("rst_busy",      busy,      1'b0);
`ifdef RFFT_HOST_CYCCNT_EN
      check("rst_run_cycles", run_cycles, 16'd0);
`endif
      Reset = 1'b0;

      // Frame 1: load, ignored s_valid in RUN, back-to-back unload
      n_writes = 0;
      send_frame(0);
      load_tail_checks();
      s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 10; i++) begin
         check("run_ignores_s_valid", s_ready, 1'b0);
         @(posedge Clk); #1;
      end
      s_valid = 1'b0;
      unload(1'b0, -1);

      // Frame 2: random output backpressure
      n_writes = 0;
      send_frame(300);
      load_tail_checks();
      unload(1'b1, -1);

      // Frame 3: reset at output beat 100, then a fresh frame
      n_writes = 0;
      send_frame(32'h700);
      load_tail_checks();
      unload(1'b0, 100);
      n_writes = 0;
      send_frame(32'h900);
      load_tail_checks();
      unload(1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
